tone_sequencer: RTL and testbench
=================================

Name: tone_sequencer

Overview:
- Parametrised successor to the single-tune music box.
- Plays NUM_CH independent note sequences, one per channel. Each sequence is held in a writable per-channel RAM.
- Each channel produces a square wave; the channels are mixed onto one 1-bit sound output for the board pin. Top level inverts it as before.
- Supports a start/stop handshake, loop mode, rests and an end marker.

Parameters:
- CLK_HZ, 50_000_000, system clock frequency.
- TICK_HZ, 1000, duration tick rate (1 ms per duration unit).
- NUM_CH, 2, number of channels (1..4).
- SEQ_DEPTH, 32, note slots per channel (power of 2).
- DIV_W, 20, half-period divider width in clocks.
- DUR_W, 8, note duration width in ticks.

Ports:
- clk, in, 1, system clock.
- reset_n, in, 1, asynchronous active-low reset.
- wr_en, in, 1, write one note slot.
- wr_ch, in, $clog2(NUM_CH), target channel.
- wr_addr, in, $clog2(SEQ_DEPTH), slot address.
- wr_div, in, DIV_W, half-period in clocks; 0 = rest.
- wr_dur, in, DUR_W, duration in ticks; 0 = end-of-sequence marker.
- wr_err, out, 1, one-cycle pulse: write rejected because busy.
- start, in, 1, pulse: begin playback of all channels from slot 0.
- stop, in, 1, pulse: abort playback.
- loop_en, in, 1, sampled at start; restart from slot 0 at end.
- mix_xor, in, 1, 0 = OR mix, 1 = XOR mix.
- busy, out, 1, playback in progress.
- done, out, 1, one-cycle pulse on natural completion.
- ch_sound, out, NUM_CH, per-channel square wave.
- sound, out, 1, mixed output.

Behaviour:
- Reset (async, reset_n=0): all outputs 0, all channels IDLE, tick counter 0. RAM contents are undefined, not cleared.
- Tick: shared counter pulses every CLK_HZ/TICK_HZ cycles, free-running from reset.
- Writes:
  - Accepted only when busy=0. The slot is updated on the next edge.
  - wr_en while busy=1 pulses wr_err the next cycle; the RAM is unchanged.
- Channel FSM states: IDLE, FETCH, PLAY, DONE.
  - IDLE --start--> FETCH, with addr=0.
  - FETCH: registered RAM read, 1-cycle latency. Loads div/dur, then:
    - dur=0 → end. If loop_en latched → FETCH with addr=0; else → DONE.
    - Otherwise → PLAY. Remaining := dur, phase counter := 0, ch_sound := 0.
  - PLAY:
    - div≠0: ch_sound toggles every div clocks, i.e. f = CLK_HZ/(2·div).
    - div=0: rest, ch_sound held 0.
    - On each tick, remaining decrements. At tick with remaining=1 → FETCH with addr+1.
  - Address wrap: after slot SEQ_DEPTH-1 is played, the channel treats it as end (loop or DONE).
  - An end marker at slot 0 without loop → DONE immediately after the 2-cycle start latency, with ch_sound staying 0.
  - DONE: ch_sound=0, hold until all channels are DONE. Then all channels → IDLE together and done pulses for 1 cycle.
- busy=1 from the cycle after accepted start until the cycle done pulses or stop takes effect.
- start while busy: ignored.
- stop: all channels → IDLE next cycle, ch_sound=0, busy=0, no done pulse.
- start and stop in the same cycle: stop wins.
- Loop mode never produces done; only stop ends playback.
- Mix: sound = mix_xor ? ^ch_sound : |ch_sound. Combinational from registered ch_sound; mix_xor may change at any time.
- Tick alignment: the tick is not realigned at start, so the first note's duration error is ≤1 tick.

Decomposition:
- Package tone_pkg:
  - typedef note_t {div, dur}.
  - enum ch_state_t {IDLE, FETCH, PLAY, DONE}.
  - function tick_div(CLK_HZ, TICK_HZ).
- Sub-module tone_channel, instantiated NUM_CH times via generate.
  - Contains the SEQ_DEPTH×note_t RAM, channel FSM, duration counter and phase counter.
  - Exposes ch_done and ch_sound.
- Top block: tick generator, write decode, busy/done/stop control, mixer.

Test Plan (sim with CLK_HZ=1000, TICK_HZ=100, tick every 10 clks):
- Load ch0 {div=5,dur=3},{dur=0}; start → ch_sound0 period 10 clks for ~30 clks; done pulses once; busy then 0.
- ch0 {div=0,dur=2},{div=2,dur=1},{dur=0}, ch1 {dur=0} → ch0 low for 20 clks, then period 4 clks for 10 clks; ch1 DONE at once; done only after ch0 finishes.
- loop_en=1, ch0 {div=3,dur=1},{dur=0} → tone repeats for 200+ clks with no done; stop → sound=0 and busy=0 the next cycle.
- wr_en during playback → wr_err=1 one cycle; RAM unchanged, verified by replay after completion.
- ch0 div=4, ch1 div=4, both started together: mix_xor=1 gives sound constant 0; mix_xor=0 gives sound equal to ch0.
- reset_n low mid-note → all outputs 0 immediately; after release, start replays from slot 0 with RAM retained.

Source files
------------

// File: rtl/tone_pkg.sv
// tone_pkg: shared note/state types and tick divider helper for the tone sequencer.
package tone_pkg;
    localparam int NOTE_DIV_MAX = 32;
    localparam int NOTE_DUR_MAX = 16;

    typedef struct packed {
        logic [NOTE_DIV_MAX-1:0] div;
        logic [NOTE_DUR_MAX-1:0] dur;
    } note_t;

    typedef enum logic [1:0] {IDLE, FETCH, PLAY, DONE} ch_state_t;

    function automatic int tick_div(input int clk_hz, input int tick_hz);
        return (clk_hz / tick_hz < 1) ? 1 : clk_hz / tick_hz;
    endfunction
endpackage

// File: rtl/tone_channel.sv
// tone_channel: one note-sequence RAM plus fetch/play FSM driving a square wave.
module tone_channel
    import tone_pkg::*;
#(
    parameter int SEQ_DEPTH = 32,
    parameter int DIV_W = 20,
    parameter int DUR_W = 8,
    localparam int AW = $clog2(SEQ_DEPTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             tick,
    input  logic             start,
    input  logic             abort,
    input  logic             release_all,
    input  logic             loop,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [DIV_W-1:0] wdiv,
    input  logic [DUR_W-1:0] wdur,
    output logic             ch_done,
    output logic             ch_sound
);
    logic [DIV_W-1:0] div_mem [SEQ_DEPTH];
    logic [DUR_W-1:0] dur_mem [SEQ_DEPTH];
    note_t            rd_q;
    ch_state_t        state_q, state_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [DIV_W-1:0] div_q, div_d, ph_q, ph_d;
    logic [DUR_W-1:0] rem_q, rem_d;
    logic             rest_q, rest_d, snd_q, snd_d;

    // Read from the next-state address so the slot is already valid during FETCH.
    always_ff @(posedge clk) begin
        if (we) begin
            div_mem[waddr] <= wdiv;
            dur_mem[waddr] <= wdur;
        end
        rd_q.div <= NOTE_DIV_MAX'(div_mem[addr_d]);
        rd_q.dur <= NOTE_DUR_MAX'(dur_mem[addr_d]);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            div_q   <= '0;
            ph_q    <= '0;
            rem_q   <= '0;
            rest_q  <= 1'b0;
            snd_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            div_q   <= div_d;
            ph_q    <= ph_d;
            rem_q   <= rem_d;
            rest_q  <= rest_d;
            snd_q   <= snd_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        div_d   = div_q;
        ph_d    = ph_q;
        rem_d   = rem_q;
        rest_d  = rest_q;
        snd_d   = snd_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = FETCH;
                    addr_d  = '0;
                end
            end
            FETCH: begin
                if (rd_q.dur == '0) begin
                    state_d = loop ? FETCH : DONE;
                    addr_d  = '0;
                end else begin
                    state_d = PLAY;
                    div_d   = rd_q.div[DIV_W-1:0];
                    rest_d  = rd_q.div == '0;
                    rem_d   = rd_q.dur[DUR_W-1:0];
                    ph_d    = '0;
                    snd_d   = 1'b0;
                end
            end
            PLAY: begin
                if (rest_q) begin
                    snd_d = 1'b0;
                end else if (ph_q + DIV_W'(1) == div_q) begin
                    ph_d  = '0;
                    snd_d = ~snd_q;
                end else begin
                    ph_d = ph_q + DIV_W'(1);
                end
                if (tick) begin
                    rem_d = rem_q - DUR_W'(1);
                    // Last tick of the note; the address wraps to 0 after the final slot.
                    if (rem_q == DUR_W'(1)) begin
                        snd_d   = 1'b0;
                        addr_d  = addr_q + AW'(1);
                        state_d = (addr_q != AW'(SEQ_DEPTH - 1) || loop) ? FETCH : DONE;
                    end
                end
            end
            DONE: begin
                snd_d = 1'b0;
                if (release_all) state_d = IDLE;
            end
        endcase
        if (abort) begin
            state_d = IDLE;
            snd_d   = 1'b0;
        end
    end

    assign ch_done  = state_q == DONE;
    assign ch_sound = snd_q;
endmodule

// File: rtl/tone_sequencer.sv
// tone_sequencer: NUM_CH sequenced square-wave channels with shared tick,
// start/stop/done control and an OR/XOR mix onto one sound bit.
module tone_sequencer
    import tone_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000,
    parameter int TICK_HZ = 1000,
    parameter int NUM_CH = 2,
    parameter int SEQ_DEPTH = 32,
    parameter int DIV_W = 20,
    parameter int DUR_W = 8,
    localparam int CH_W = NUM_CH > 1 ? $clog2(NUM_CH) : 1,
    localparam int AW = $clog2(SEQ_DEPTH)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wr_en,
    input  logic [CH_W-1:0]   wr_ch,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DIV_W-1:0]  wr_div,
    input  logic [DUR_W-1:0]  wr_dur,
    output logic              wr_err,
    input  logic              start,
    input  logic              stop,
    input  logic              loop_en,
    input  logic              mix_xor,
    output logic              busy,
    output logic              done,
    output logic [NUM_CH-1:0] ch_sound,
    output logic              sound
);
    localparam int TICK_DIV = tick_div(CLK_HZ, TICK_HZ);
    localparam int TW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;

    logic [TW-1:0]     cnt_q, cnt_d;
    logic              busy_q, busy_d, done_q, done_d, wr_err_q, wr_err_d, loop_q, loop_d;
    logic              tick, start_go, all_done, wr_ok;
    logic [NUM_CH-1:0] ch_done;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            wr_err_q <= 1'b0;
            loop_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            wr_err_q <= wr_err_d;
            loop_q   <= loop_d;
        end
    end

    always_comb begin
        tick     = cnt_q == TW'(TICK_DIV - 1);
        cnt_d    = tick ? '0 : cnt_q + TW'(1);
        start_go = start & ~busy_q & ~stop;
        all_done = &ch_done;
        wr_ok    = wr_en & ~busy_q;
        busy_d   = stop ? 1'b0 : start_go ? 1'b1 : busy_q & ~all_done;
        done_d   = busy_q & all_done & ~stop;
        wr_err_d = wr_en & busy_q;
        loop_d   = start_go ? loop_en : loop_q;
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        tone_channel #(
            .SEQ_DEPTH(SEQ_DEPTH),
            .DIV_W    (DIV_W),
            .DUR_W    (DUR_W)
        ) u_ch (
            .clk        (clk),
            .reset_n    (reset_n),
            .tick       (tick),
            .start      (start_go),
            .abort      (stop),
            .release_all(all_done),
            .loop       (loop_q),
            .we         (wr_ok && wr_ch == CH_W'(i)),
            .waddr      (wr_addr),
            .wdiv       (wr_div),
            .wdur       (wr_dur),
            .ch_done    (ch_done[i]),
            .ch_sound   (ch_sound[i])
        );
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign wr_err = wr_err_q;
    assign sound  = mix_xor ? ^ch_sound : |ch_sound;
endmodule

// File: tb/tb_tone_sequencer.sv
// tb_tone_sequencer: directed playback scenarios with a queued-expectation scoreboard.
module tb_tone_sequencer;
    logic       clk = 0, reset_n = 0, wr_en = 0, start = 0, stop = 0, loop_en = 0, mix_xor = 0;
    logic [0:0] wr_ch = '0;
    logic [4:0] wr_addr = '0;
    logic [19:0] wr_div = '0;
    logic [7:0] wr_dur = '0;
    logic       wr_err, busy, done, sound;
    logic [1:0] ch_sound;

    int checks = 0, failures = 0;
    int exp_q[$];
    string tag_q[$];
    int m_rise[3], m_first[3], m_per[3], m_hi[3];
    int m_nd, m_tdone, m_busy3, m_busy_done;

    tone_sequencer #(
        .CLK_HZ(1000), .TICK_HZ(100), .NUM_CH(2), .SEQ_DEPTH(32), .DIV_W(20), .DUR_W(8)
    ) dut (
        .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_ch(wr_ch), .wr_addr(wr_addr),
        .wr_div(wr_div), .wr_dur(wr_dur), .wr_err(wr_err), .start(start), .stop(stop),
        .loop_en(loop_en), .mix_xor(mix_xor), .busy(busy), .done(done),
        .ch_sound(ch_sound), .sound(sound)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic expect_v(input string t, input int v);
        tag_q.push_back(t);
        exp_q.push_back(v);
    endtask

    task automatic check_next(input logic [31:0] obs);
        string t;
        int e;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $error("FAIL scoreboard_empty: observed=%0d required=none", obs);
            return;
        end
        t = tag_q.pop_front();
        e = exp_q.pop_front();
        assert (obs === 32'(e)) else begin
            failures++;
            $error("FAIL %s: observed=%0d required=%0d", t, $signed(obs), e);
        end
    endtask

    task automatic write_note(input int ch, input int a, input int dv, input int du);
        wr_en = 1; wr_ch = 1'(ch); wr_addr = 5'(a); wr_div = 20'(dv); wr_dur = 8'(du);
        @(posedge clk);
        #1 wr_en = 0;
        @(negedge clk);
    endtask

    task automatic go();
        start = 1;
        @(posedge clk);
        #1 start = 0;
    endtask

    // Samples ch_sound[0], ch_sound[1], sound on each negedge; cycle 1 is the first after start.
    task automatic watch(input int maxc, input bit until_done);
        logic [2:0] s, p;
        int run [3];
        int last [3];
        p = '0;
        m_nd = 0; m_tdone = -1; m_busy3 = -1; m_busy_done = -1;
        for (int k = 0; k < 3; k++) begin
            m_rise[k] = 0; m_first[k] = -1; m_per[k] = 0; m_hi[k] = 0; run[k] = 0; last[k] = 0;
        end
        for (int c = 1; c <= maxc; c++) begin
            @(negedge clk);
            s = {sound, ch_sound};
            for (int k = 0; k < 3; k++) begin
                if (s[k] === 1'b1) begin
                    run[k]++;
                    if (run[k] > m_hi[k]) m_hi[k] = run[k];
                    if (p[k] !== 1'b1) begin
                        m_rise[k]++;
                        if (m_first[k] < 0) m_first[k] = c;
                        else m_per[k] = c - last[k];
                        last[k] = c;
                    end
                end else run[k] = 0;
            end
            p = s;
            if (c == 3) m_busy3 = int'(busy);
            if (done === 1'b1) begin
                m_nd++;
                if (m_tdone < 0) begin
                    m_tdone = c;
                    m_busy_done = int'(busy);
                end
                if (until_done) begin
                    @(negedge clk);
                    if (done === 1'b1) m_nd++;
                    return;
                end
            end
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        expect_v("rst_busy", 0); expect_v("rst_done", 0); expect_v("rst_wr_err", 0);
        expect_v("rst_ch_sound", 0); expect_v("rst_sound", 0);
        check_next(busy); check_next(done); check_next(wr_err); check_next(ch_sound); check_next(sound);
        reset_n = 1;
        @(negedge clk);

        write_note(0, 0, 5, 3); write_note(0, 1, 0, 0); write_note(1, 0, 0, 0);
        expect_v("t1_wr_err_idle", 0);
        check_next(wr_err);
        expect_v("t1_first_rise", 7); expect_v("t1_period", 10); expect_v("t1_high_run", 5);
        expect_v("t1_rises_2to3", 1); expect_v("t1_done_count", 1); expect_v("t1_done_window", 1);
        expect_v("t1_busy_c3", 1); expect_v("t1_busy_at_done", 0); expect_v("t1_ch1_silent", 0);
        go(); watch(120, 1);
        check_next(m_first[0]); check_next(m_per[0]); check_next(m_hi[0]);
        check_next(m_rise[0] >= 2 && m_rise[0] <= 3); check_next(m_nd);
        check_next(m_tdone >= 25 && m_tdone <= 34); check_next(m_busy3); check_next(m_busy_done);
        check_next(m_rise[1]);

        write_note(0, 0, 0, 2); write_note(0, 1, 2, 1); write_note(0, 2, 0, 0);
        expect_v("t2_rest_window", 1); expect_v("t2_period", 4); expect_v("t2_high_run", 2);
        expect_v("t2_rises", 2); expect_v("t2_done_after_tone", 9); expect_v("t2_ch1_silent", 0);
        expect_v("t2_busy_c3", 1); expect_v("t2_done_count", 1);
        go(); watch(120, 1);
        check_next(m_first[0] >= 16 && m_first[0] <= 25); check_next(m_per[0]); check_next(m_hi[0]);
        check_next(m_rise[0]); check_next(m_tdone - m_first[0]); check_next(m_rise[1]);
        check_next(m_busy3); check_next(m_nd);

        write_note(0, 0, 3, 1); write_note(0, 1, 0, 0);
        loop_en = 1;
        expect_v("t3_no_done", 0); expect_v("t3_high_run", 3); expect_v("t3_loop_period", 10);
        expect_v("t3_many_rises", 1); expect_v("t3_busy", 1);
        go(); loop_en = 0; watch(250, 0);
        check_next(m_nd); check_next(m_hi[0]); check_next(m_per[0]); check_next(m_rise[0] >= 20);
        check_next(busy);
        expect_v("t3_stop_busy", 0); expect_v("t3_stop_ch_sound", 0); expect_v("t3_stop_sound", 0);
        expect_v("t3_stop_no_done", 0);
        stop = 1;
        @(posedge clk);
        #1 stop = 0;
        @(negedge clk);
        check_next(busy); check_next(ch_sound); check_next(sound);
        watch(20, 0);
        check_next(m_nd);

        expect_v("ss_busy", 0); expect_v("ss_no_done", 0); expect_v("ss_silent", 0);
        start = 1; stop = 1;
        @(posedge clk);
        #1 begin start = 0; stop = 0; end
        @(negedge clk);
        check_next(busy);
        watch(15, 0);
        check_next(m_nd); check_next(m_rise[0]);

        write_note(0, 0, 5, 3); write_note(0, 1, 0, 0);
        expect_v("t4_wr_err_pulse", 1); expect_v("t4_wr_err_clear", 0); expect_v("t4_done_seen", 1);
        go();
        repeat (3) @(negedge clk);
        write_note(0, 0, 7, 1);
        check_next(wr_err);
        @(negedge clk);
        check_next(wr_err);
        for (int c = 0; c < 150 && done !== 1'b1; c++) @(negedge clk);
        check_next(done);
        @(negedge clk);
        expect_v("t4_replay_first", 7); expect_v("t4_replay_high", 5); expect_v("t4_replay_period", 10);
        expect_v("t4_replay_done", 1);
        go(); watch(120, 1);
        check_next(m_first[0]); check_next(m_hi[0]); check_next(m_per[0]); check_next(m_nd);

        write_note(0, 0, 4, 3); write_note(0, 1, 0, 0); write_note(1, 0, 4, 3); write_note(1, 1, 0, 0);
        mix_xor = 1;
        expect_v("t5_xor_silent", 0); expect_v("t5_ch0_active", 1); expect_v("t5_ch1_first", 6);
        expect_v("t5_done", 1);
        go(); watch(120, 1);
        check_next(m_rise[2]); check_next(m_rise[0] >= 2); check_next(m_first[1]); check_next(m_nd);
        mix_xor = 0;
        expect_v("t5_or_first", 6); expect_v("t5_or_period", 8); expect_v("t5_or_high", 4);
        go(); watch(120, 1);
        check_next(m_first[2]); check_next(m_per[2]); check_next(m_hi[2]);

        expect_v("t6_pre_high", 1); expect_v("t6_rst_ch_sound", 0); expect_v("t6_rst_sound", 0);
        expect_v("t6_rst_busy", 0); expect_v("t6_rst_done", 0);
        go();
        repeat (8) @(negedge clk);
        check_next(ch_sound[0]);
        #2 reset_n = 0;
        #1;
        check_next(ch_sound); check_next(sound); check_next(busy); check_next(done);
        @(negedge clk);
        reset_n = 1;
        @(negedge clk);
        expect_v("t6_replay_first", 6); expect_v("t6_replay_high", 4); expect_v("t6_replay_done", 1);
        go(); watch(120, 1);
        check_next(m_first[0]); check_next(m_hi[0]); check_next(m_nd);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
